// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction memory write port of the boot loader
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // Host side: sources the framed byte stream and observes memory writes.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  // Loader side: sinks the byte stream and drives the memory write port.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction memory loader with XOR checksum
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  imem_loader_if.slave bus,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [8:0]  words_written_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_COLLECT = 3'd2,
    S_WRITE   = 3'd3,
    S_CHECK   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // A header byte of zero stands for a full memory-sized frame.
  localparam logic [8:0] FULL_COUNT = 9'(DEPTH);

  state_t      state_q, state_d;
  logic [8:0]  count_q, count_d;
  logic [7:0]  chk_q, chk_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [31:0] word_q, word_d;
  logic [8:0]  words_written_q, words_written_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        accept;

  // in_ready_q already reflects the current state, so a transfer never waits on in_valid.
  assign accept = bus.in_valid & in_ready_q;

  // State and all registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      count_q         <= '0;
      chk_q           <= '0;
      byte_idx_q      <= '0;
      word_idx_q      <= '0;
      word_q          <= '0;
      words_written_q <= '0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      busy_q          <= 1'b0;
      cpu_hold_q      <= 1'b0;
      in_ready_q      <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      chk_q           <= chk_d;
      byte_idx_q      <= byte_idx_d;
      word_idx_q      <= word_idx_d;
      word_q          <= word_d;
      words_written_q <= words_written_d;
      done_q          <= done_d;
      error_q         <= error_d;
      busy_q          <= busy_d;
      cpu_hold_q      <= cpu_hold_d;
      in_ready_q      <= in_ready_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  // Next-state, frame datapath and next values of the registered outputs.
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    chk_d           = chk_q;
    byte_idx_d      = byte_idx_q;
    word_idx_d      = word_idx_q;
    word_d          = word_q;
    words_written_d = words_written_q;
    done_d          = done_q;
    error_d         = error_q;
    mem_we_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          done_d          = 1'b0;
          error_d         = 1'b0;
          words_written_d = '0;
          state_d         = S_HEADER;
        end
      end

      S_HEADER: begin
        if (accept) begin
          count_d    = (bus.in_data == 8'd0) ? FULL_COUNT : {1'b0, bus.in_data};
          chk_d      = bus.in_data;
          byte_idx_d = '0;
          word_idx_d = '0;
          state_d    = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (accept) begin
          word_d     = {word_q[23:0], bus.in_data};
          chk_d      = chk_q ^ bus.in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // The write port registers load here so the pulse lines up with the WRITE state.
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_ADDR + {22'd0, word_idx_q, 2'b00};
            mem_wdata_d = word_d;
            state_d     = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        word_idx_d      = word_idx_q + 8'd1;
        words_written_d = words_written_q + 9'd1;
        byte_idx_d      = '0;
        if ({1'b0, word_idx_q} == (count_q - 9'd1)) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_COLLECT;
        end
      end

      S_CHECK: begin
        if (accept) begin
          error_d = (bus.in_data != chk_q);
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are registered from the state being entered.
  logic busy_next;
  always_comb begin
    busy_next  = (state_d == S_HEADER) || (state_d == S_COLLECT) ||
                 (state_d == S_WRITE)  || (state_d == S_CHECK);
    busy_d     = busy_next;
    cpu_hold_d = busy_next;
    in_ready_d = (state_d == S_HEADER) || (state_d == S_COLLECT) || (state_d == S_CHECK);
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign cpu_hold_o       = cpu_hold_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign words_written_o  = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic       cpu_hold_o;
  logic       busy_o;
  logic       done_o;
  logic       error_o;
  logic [8:0] words_written_o;

  imem_loader_if bus_if ();

  imem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .DEPTH     (256)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .bus             (bus_if.slave),
    .cpu_hold_o      (cpu_hold_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .words_written_o (words_written_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt;
  int total_cnt;
  int hold_cnt;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] words_a[256];

  // Observe the write port and the CPU hold away from the active edge.
  always @(negedge clk) begin
    if (bus_if.mem_we) begin
      wr_addr.push_back(bus_if.mem_addr);
      wr_data.push_back(bus_if.mem_wdata);
    end
    if (cpu_hold_o) hold_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    hold_cnt = 0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   n;
    logic rdy;
    if (gap > 0) begin
      bus_if.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus_if.in_data  = b;
    bus_if.in_valid = 1'b1;
    n = 0;
    do begin
      rdy = bus_if.in_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 300);
    if (!rdy) check("ready_timeout", {31'd0, bus_if.in_ready}, 32'd1);
  endtask

  // Sends header, nwords words from words_a and the checksum (optionally corrupted).
  task automatic send_frame(input logic [7:0] n, input int gap, input logic [7:0] chk_flip,
                            input bit hold_start);
    int          nwords;
    logic [7:0]  chk;
    logic [31:0] w;
    nwords = (n == 8'd0) ? 256 : int'(n);
    chk = n;
    if (hold_start) start_i = 1'b1;
    send_byte(n, gap);
    for (int i = 0; i < nwords; i++) begin
      w = words_a[i];
      for (int k = 3; k >= 0; k--) begin
        chk = chk ^ w[k*8 +: 8];
        send_byte(w[k*8 +: 8], gap);
      end
    end
    start_i = 1'b0;
    send_byte(chk ^ chk_flip, gap);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done_o}, 32'd1);
  endtask

  int bad;

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    hold_cnt        = 0;
    rst_n           = 1'b0;
    start_i         = 1'b1;
    bus_if.in_data  = 8'h00;
    bus_if.in_valid = 1'b0;

    // Reset held with start asserted.
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, bus_if.mem_we}, 32'd0);
    check("rst_mem_addr", bus_if.mem_addr, 32'd0);
    check("rst_mem_wdata", bus_if.mem_wdata, 32'd0);
    check("rst_flags", {28'd0, cpu_hold_o, busy_o, done_o, error_o}, 32'd0);
    check("rst_words", {23'd0, words_written_o}, 32'd0);
    check("rst_no_write", wr_addr.size(), 32'd0);
    start_i = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy_o}, 32'd0);

    // Single word at full rate: 01 20 08 00 05 2C.
    clear_log();
    words_a[0] = 32'h2008_0005;
    pulse_start();
    check("start_busy", {30'd0, busy_o, cpu_hold_o}, 32'd3);
    send_frame(8'h01, 0, 8'h00, 1'b0);
    wait_done();
    check("w1_count", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("w1_addr", wr_addr[0], 32'h0000_0000);
      check("w1_data", wr_data[0], 32'h2008_0005);
    end
    check("w1_error", {31'd0, error_o}, 32'd0);
    check("w1_words", {23'd0, words_written_o}, 32'd1);
    check("w1_hold_cycles", hold_cnt, 32'd7);
    check("w1_done_release", {30'd0, busy_o, cpu_hold_o}, 32'd0);
    repeat (2) @(negedge clk);
    check("w1_done_sticky", {31'd0, done_o}, 32'd1);

    // Three words, in_valid toggling, start held high (ignored while busy).
    clear_log();
    words_a[0] = 32'h0011_2233;
    words_a[1] = 32'hDEAD_BEEF;
    words_a[2] = 32'h1357_9BDF;
    pulse_start();
    send_frame(8'h03, 1, 8'h00, 1'b1);
    wait_done();
    check("w3_count", wr_addr.size(), 32'd3);
    if (wr_addr.size() == 3) begin
      check("w3_addr0", wr_addr[0], 32'h0000_0000);
      check("w3_data0", wr_data[0], 32'h0011_2233);
      check("w3_addr1", wr_addr[1], 32'h0000_0004);
      check("w3_data1", wr_data[1], 32'hDEAD_BEEF);
      check("w3_addr2", wr_addr[2], 32'h0000_0008);
      check("w3_data2", wr_data[2], 32'h1357_9BDF);
    end
    check("w3_error", {31'd0, error_o}, 32'd0);
    check("w3_words", {23'd0, words_written_o}, 32'd3);
    check("w3_hold_addr", bus_if.mem_addr, 32'h0000_0008);
    @(negedge clk);

    // Bad checksum: 2D instead of 2C.
    clear_log();
    words_a[0] = 32'h2008_0005;
    pulse_start();
    send_frame(8'h01, 0, 8'h01, 1'b0);
    wait_done();
    check("bad_count", wr_addr.size(), 32'd1);
    check("bad_error", {31'd0, error_o}, 32'd1);
    check("bad_words", {23'd0, words_written_o}, 32'd1);
    repeat (2) @(negedge clk);
    pulse_start();
    check("restart_clear", {22'd0, words_written_o, done_o}, 32'd0);
    check("restart_err_clear", {31'd0, error_o}, 32'd0);
    words_a[0] = 32'hCAFE_F00D;
    send_frame(8'h01, 0, 8'h00, 1'b0);
    wait_done();
    @(negedge clk);

    // N=0 means 256 words, last one at 0x3FC.
    clear_log();
    for (int i = 0; i < 256; i++) begin
      words_a[i] = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
    end
    pulse_start();
    send_frame(8'h00, 0, 8'h00, 1'b0);
    wait_done();
    check("w256_count", wr_addr.size(), 32'd256);
    if (wr_addr.size() == 256) begin
      check("w256_last_addr", wr_addr[255], 32'h0000_03FC);
      check("w256_last_data", wr_data[255], 32'hFF00_A5C3);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== words_a[i]) bad++;
      end
      check("w256_all_words", bad, 32'd0);
    end
    check("w256_words", {23'd0, words_written_o}, 32'd256);
    check("w256_error", {31'd0, error_o}, 32'd0);
    @(negedge clk);

    // Abort after the second data byte, then load a clean frame.
    clear_log();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    bus_if.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_flags", {27'd0, bus_if.in_ready, cpu_hold_o, busy_o, done_o, error_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_write", wr_addr.size(), 32'd0);
    words_a[0] = 32'h2008_0005;
    pulse_start();
    send_frame(8'h01, 0, 8'h00, 1'b0);
    wait_done();
    check("reload_count", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("reload_addr", wr_addr[0], 32'h0000_0000);
      check("reload_data", wr_data[0], 32'h2008_0005);
    end
    check("reload_error", {31'd0, error_o}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
